// File: rtl/i4004_fetch_seq.sv
// ---------------------------------------------------------------------------
// i4004_fetch_seq
//
// CPU-side instruction-fetch sequencer for the MCS-4 bus. It free-runs the
// eight-clock instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3), drives the 12-bit
// fetch address onto the bus in nibbles during A1..A3, and captures the
// OPR/OPA nibbles returned by the 4001 ROMs during M1/M2. The assembled
// byte goes to the execute unit over a valid/ready handshake. When the
// execute unit back-pressures, the fetched byte is dropped and the same
// address is fetched again on the next instruction cycle, so the bus never
// stalls. Jump requests redirect the fetch address at the next cycle boundary.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   sync         high during X3 (responders restart their phase count on it)
//   cm_rom       high during A3 only
//   dbus_out     address nibble driven to the bus, 0 outside A1..A3
//   dbus_in      wired-OR of responder outputs (OPR in M1, OPA in M2)
//   instr        fetched byte {OPR, OPA}
//   instr_pc     address instr was fetched from
//   instr_valid  instr/instr_pc valid, held until accepted
//   instr_ready  execute unit accepts when valid & ready at a posedge
//   jmp_valid    single-cycle redirect request
//   jmp_addr     redirect target
// ---------------------------------------------------------------------------

package mcs4;
    typedef logic [3:0] char_t;
    typedef logic [7:0] byte_t;
    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } instr_cyc_t;
endpackage

module i4004_fetch_seq #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        sync,
    output logic        cm_rom,
    output mcs4::char_t dbus_out,
    input  mcs4::char_t dbus_in,
    output mcs4::byte_t instr,
    output logic [11:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jmp_valid,
    input  logic [11:0] jmp_addr
);

    import mcs4::*;

    instr_cyc_t  cyc;
    instr_cyc_t  cyc_next;

    logic [11:0] fetch_pc;
    logic [11:0] fetch_pc_next;
    logic [11:0] jmp_target;
    logic [11:0] jmp_target_next;
    logic        jmp_pending;
    logic        jmp_pending_next;
    logic        accepted;
    logic        accepted_next;
    logic        valid_next;
    char_t       opr;

    logic        handshake;
    logic        write_ok;
    logic [11:0] redirect_pc;

    // Phase counter register. Reset parks it in X3 so the first cycle after
    // reset release is A1 fetching RESET_PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc <= X3;
        end else begin
            cyc <= cyc_next;
        end
    end

    // Phase sequencing: the cycle never waits for anything, it simply
    // advances one phase per clock and wraps X3 -> A1.
    always_comb begin
        cyc_next = cyc;
        case (cyc)
            A1:      cyc_next = A2;
            A2:      cyc_next = A3;
            A3:      cyc_next = M1;
            M1:      cyc_next = M2;
            M2:      cyc_next = X1;
            X1:      cyc_next = X2;
            X2:      cyc_next = X3;
            X3:      cyc_next = A1;
            default: cyc_next = A1;
        endcase
    end

    // sync and cm_rom are registered decodes of the next phase so they
    // change cleanly on the clock edge without decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= 1'b1;
            cm_rom <= 1'b0;
        end else begin
            sync   <= (cyc_next == X3);
            cm_rom <= (cyc_next == A3);
        end
    end

    // Address nibbles go out low-first during A1..A3; the bus is released
    // (driven to zero) in every other phase so the wired-OR stays clean.
    always_comb begin
        dbus_out = 4'h0;
        case (cyc)
            A1:      dbus_out = fetch_pc[3:0];
            A2:      dbus_out = fetch_pc[7:4];
            A3:      dbus_out = fetch_pc[11:8];
            default: dbus_out = 4'h0;
        endcase
    end

    // Fetch control. A byte completed at the end of M2 is only handed over
    // if the output slot is free (or being emptied this edge) and no jump
    // is pending or arriving; otherwise it is dropped and "accepted" stays
    // low so the same address is refetched. A jump flushes the output slot.
    always_comb begin
        handshake        = instr_valid && instr_ready;
        write_ok         = (cyc == M2) && (!instr_valid || instr_ready)
                           && !jmp_pending && !jmp_valid;
        redirect_pc      = jmp_valid ? jmp_addr : jmp_target;

        valid_next       = instr_valid;
        accepted_next    = accepted;
        fetch_pc_next    = fetch_pc;
        jmp_pending_next = jmp_pending;
        jmp_target_next  = jmp_target;

        if (write_ok) begin
            valid_next = 1'b1;
        end else if (jmp_valid || handshake) begin
            valid_next = 1'b0;
        end

        if (jmp_valid) begin
            jmp_target_next  = jmp_addr;
            jmp_pending_next = 1'b1;
        end

        if (cyc == M2) begin
            accepted_next = write_ok;
        end

        // Cycle boundary: redirect wins over increment; a dropped byte
        // leaves the address unchanged so it is fetched again.
        if (cyc == X3) begin
            if (jmp_pending || jmp_valid) begin
                fetch_pc_next = redirect_pc;
            end else if (accepted) begin
                fetch_pc_next = fetch_pc + 12'd1;
            end
            jmp_pending_next = 1'b0;
            accepted_next    = 1'b0;
        end
    end

    // Datapath registers. OPR is latched at the end of M1 and combined
    // with OPA straight off the bus at the end of M2.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            jmp_target  <= 12'h000;
            jmp_pending <= 1'b0;
            accepted    <= 1'b0;
            opr         <= 4'h0;
            instr       <= 8'h00;
            instr_pc    <= 12'h000;
            instr_valid <= 1'b0;
        end else begin
            fetch_pc    <= fetch_pc_next;
            jmp_target  <= jmp_target_next;
            jmp_pending <= jmp_pending_next;
            accepted    <= accepted_next;
            instr_valid <= valid_next;
            if (cyc == M1) begin
                opr <= dbus_in;
            end
            if (write_ok) begin
                instr    <= {opr, dbus_in};
                instr_pc <= fetch_pc;
            end
        end
    end

endmodule

// File: tb/tb_i4004_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_i4004_fetch_seq
//
// Self-checking bench for i4004_fetch_seq. A 4001-style ROM responder serves
// the main instance; an instruction-cycle-level reference model (phase count
// since reset, fetch address, one-entry output slot, ROM looked up directly
// by address) is compared against the DUT on every clock. Directed literal
// checks pin the model to hand-computed values. A second instance with
// RESET_PC = 12'hFFF checks the address wrap.
// ---------------------------------------------------------------------------

module tb_i4004_fetch_seq;

    import mcs4::*;

    localparam int A1P = 0;
    localparam int A2P = 1;
    localparam int A3P = 2;
    localparam int M1P = 3;
    localparam int M2P = 4;
    localparam int X1P = 5;
    localparam int X3P = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_ready;
    logic        jmp_valid;
    logic [11:0] jmp_addr;
    char_t       dbus_in;
    char_t       dbus_out;
    byte_t       instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        sync;
    logic        cm_rom;

    logic        sync2;
    logic        cm_rom2;
    char_t       dbus_out2;
    byte_t       instr2;
    logic [11:0] instr_pc2;
    logic        instr_valid2;
    logic        ready2 = 1'b1;
    logic        jv2 = 1'b0;
    logic [11:0] ja2 = 12'h000;
    char_t       din2 = 4'h0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i4004_fetch_seq #(.RESET_PC(12'h000)) dut (
        .clk         (clk),
        .rst         (rst),
        .sync        (sync),
        .cm_rom      (cm_rom),
        .dbus_out    (dbus_out),
        .dbus_in     (dbus_in),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jmp_valid   (jmp_valid),
        .jmp_addr    (jmp_addr)
    );

    i4004_fetch_seq #(.RESET_PC(12'hFFF)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .sync        (sync2),
        .cm_rom      (cm_rom2),
        .dbus_out    (dbus_out2),
        .dbus_in     (din2),
        .instr       (instr2),
        .instr_pc    (instr_pc2),
        .instr_valid (instr_valid2),
        .instr_ready (ready2),
        .jmp_valid   (jv2),
        .jmp_addr    (ja2)
    );

    // ROM contents and 4001-style responder: counts phases from sync,
    // latches the address nibbles in A1..A3, answers in M1/M2.
    byte_t       rom [4096];
    int          rom_cnt = 0;
    logic [11:0] rom_addr = 12'h000;
    byte_t       rom_byte;

    always @(posedge clk) begin
        if (rst || sync) begin
            rom_cnt <= 0;
        end else begin
            rom_cnt <= rom_cnt + 1;
        end
        case (rom_cnt)
            0:       rom_addr[3:0]  <= dbus_out;
            1:       rom_addr[7:4]  <= dbus_out;
            2:       rom_addr[11:8] <= dbus_out;
            default: ;
        endcase
    end

    always_comb begin
        rom_byte = rom[rom_addr];
        dbus_in  = 4'h0;
        if (rom_cnt == 3) dbus_in = rom_byte[7:4];
        if (rom_cnt == 4) dbus_in = rom_byte[3:0];
    end

    // Reference model, advanced once per clock from the bench's inputs.
    int          m_phase = X3P;
    logic [11:0] m_pc = 12'h000;
    logic [11:0] m_ipc = 12'h000;
    logic [11:0] m_jtgt = 12'h000;
    byte_t       m_instr = 8'h00;
    bit          m_valid = 1'b0;
    bit          m_jpend = 1'b0;
    bit          m_got = 1'b0;
    bit          m_live = 1'b0;
    bit          m_fire;
    bit          m_deliver;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = X3P;
            m_pc    = 12'h000;
            m_ipc   = 12'h000;
            m_instr = 8'h00;
            m_valid = 1'b0;
            m_jpend = 1'b0;
            m_got   = 1'b0;
            m_live  = 1'b1;
        end else begin
            m_fire    = m_valid && instr_ready;
            m_deliver = (m_phase == M2P) && (!m_valid || instr_ready)
                        && !m_jpend && !jmp_valid;
            if (m_deliver) begin
                m_instr = rom[m_pc];
                m_ipc   = m_pc;
                m_valid = 1'b1;
            end else if (jmp_valid || m_fire) begin
                m_valid = 1'b0;
            end
            if (m_phase == M2P) m_got = m_deliver;
            if (m_phase == X3P) begin
                if (jmp_valid)    m_pc = jmp_addr;
                else if (m_jpend) m_pc = m_jtgt;
                else if (m_got)   m_pc = m_pc + 12'd1;
                m_jpend = 1'b0;
                m_got   = 1'b0;
            end else if (jmp_valid) begin
                m_jpend = 1'b1;
                m_jtgt  = jmp_addr;
            end
            m_phase = (m_phase + 1) % 8;
        end
    end

    // Record what the execute unit actually consumed.
    logic [11:0] consumed [$];

    always @(posedge clk) begin
        if (!rst && instr_valid && instr_ready) consumed.push_back(instr_pc);
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy,
                                 input logic jv, input logic [11:0] ja);
        rst         = r;
        instr_ready = rdy;
        jmp_valid   = jv;
        jmp_addr    = ja;
    endtask

    task automatic waitPhase(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_phase != p && n < 64);
        if (m_phase != p) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL waitPhase: phase %0d not reached, got %0d", p, m_phase);
        end
    endtask

    // Per-clock comparison of the DUT against the model.
    logic [3:0] exp_bus;

    always @(negedge clk) begin
        if (m_live) begin
            case (m_phase)
                A1P:     exp_bus = m_pc[3:0];
                A2P:     exp_bus = m_pc[7:4];
                A3P:     exp_bus = m_pc[11:8];
                default: exp_bus = 4'h0;
            endcase
            checkOutput("model_sync", sync, m_phase == X3P);
            checkOutput("model_cm_rom", cm_rom, m_phase == A3P);
            checkOutput("model_dbus_out", dbus_out, exp_bus);
            checkOutput("model_instr_valid", instr_valid, m_valid);
            checkOutput("model_instr", instr, m_instr);
            checkOutput("model_instr_pc", instr_pc, m_ipc);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 4096; i++) rom[i] = byte_t'((i * 37 + 11) % 256);
        rom[0]        = 8'h12;
        rom[1]        = 8'hD4;
        rom[2]        = 8'h6B;
        rom[12'h3A5]  = 8'hC7;

        // ---- reset and free-running cycle ----
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        repeat (3) @(negedge clk);
        checkOutput("rst_sync", sync, 1'b1);
        checkOutput("rst_valid", instr_valid, 1'b0);
        checkOutput("rst_dbus", dbus_out, 4'h0);
        checkOutput("rst_cm_rom", cm_rom, 1'b0);
        checkOutput("rst_sync2", sync2, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);

        waitPhase(A1P);
        checkOutput("c1_a1_dbus", dbus_out, 4'h0);
        checkOutput("c1_a1_sync", sync, 1'b0);
        checkOutput("c1_a1_dbus2", dbus_out2, 4'hF);
        waitPhase(A2P);
        checkOutput("c1_a2_dbus", dbus_out, 4'h0);
        waitPhase(A3P);
        checkOutput("c1_a3_dbus", dbus_out, 4'h0);
        checkOutput("c1_a3_cm_rom", cm_rom, 1'b1);
        checkOutput("c1_a3_cm_rom2", cm_rom2, 1'b1);
        waitPhase(X1P);
        checkOutput("c1_x1_valid", instr_valid, 1'b1);
        checkOutput("c1_x1_instr", instr, 8'h12);
        checkOutput("c1_x1_pc", instr_pc, 12'h000);
        checkOutput("c1_x1_pc2", instr_pc2, 12'hFFF);
        checkOutput("c1_x1_valid2", instr_valid2, 1'b1);
        checkOutput("c1_x1_instr2", instr2, 8'h00);
        waitPhase(A1P);
        checkOutput("c2_a1_dbus", dbus_out, 4'h1);
        waitPhase(X1P);
        checkOutput("c2_x1_instr", instr, 8'hD4);
        checkOutput("c2_x1_pc", instr_pc, 12'h001);
        checkOutput("c2_x1_pc2", instr_pc2, 12'h000);
        waitPhase(X3P);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sync && n < 20);
        checkOutput("sync_period", n, 8);

        // ---- back-pressure: refetch without skip or duplicate ----
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
        consumed.delete();
        waitPhase(X1P);
        checkOutput("bp_c1_instr", instr, 8'h12);
        for (int k = 0; k < 3; k++) begin
            waitPhase(A1P);
            checkOutput("bp_refetch_dbus", dbus_out, 4'h1);
            waitPhase(X1P);
            checkOutput("bp_hold_valid", instr_valid, 1'b1);
            checkOutput("bp_hold_instr", instr, 8'h12);
            checkOutput("bp_hold_pc", instr_pc, 12'h000);
        end
        waitPhase(A1P);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
        waitPhase(X1P);
        checkOutput("bp_next_instr", instr, 8'hD4);
        checkOutput("bp_next_pc", instr_pc, 12'h001);
        waitPhase(A1P);
        checkOutput("bp_after_dbus", dbus_out, 4'h2);
        waitPhase(X1P);
        checkOutput("bp_after_pc", instr_pc, 12'h002);
        checkOutput("bp_after_instr", instr, 8'h6B);
        checkOutput("bp_consumed_n", consumed.size(), 2);
        if (consumed.size() >= 2) begin
            checkOutput("bp_consumed0", consumed[0], 12'h000);
            checkOutput("bp_consumed1", consumed[1], 12'h001);
        end

        // ---- jump at M1 while an instruction is held ----
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
        waitPhase(M1P);
        checkOutput("jmp_pre_valid", instr_valid, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 12'h3A5);
        waitPhase(M2P);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
        checkOutput("jmp_flush_valid", instr_valid, 1'b0);
        waitPhase(X1P);
        checkOutput("jmp_drop_valid", instr_valid, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
        waitPhase(A1P);
        checkOutput("jmp_a1_dbus", dbus_out, 4'h5);
        waitPhase(A2P);
        checkOutput("jmp_a2_dbus", dbus_out, 4'hA);
        waitPhase(A3P);
        checkOutput("jmp_a3_dbus", dbus_out, 4'h3);
        waitPhase(X1P);
        checkOutput("jmp_x1_valid", instr_valid, 1'b1);
        checkOutput("jmp_x1_pc", instr_pc, 12'h3A5);
        checkOutput("jmp_x1_instr", instr, 8'hC7);

        // ---- reset asserted at M2 with a held instruction ----
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
        waitPhase(M2P);
        checkOutput("mrst_pre_valid", instr_valid, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
        @(negedge clk);
        checkOutput("mrst_valid", instr_valid, 1'b0);
        checkOutput("mrst_sync", sync, 1'b1);
        checkOutput("mrst_pc", instr_pc, 12'h000);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
        waitPhase(A1P);
        checkOutput("mrst_a1_dbus", dbus_out, 4'h0);
        waitPhase(X1P);
        checkOutput("mrst_x1_valid", instr_valid, 1'b1);
        checkOutput("mrst_x1_pc", instr_pc, 12'h000);
        checkOutput("mrst_x1_instr", instr, 8'h12);
        checkOutput("mrst_x1_pc2", instr_pc2, 12'hFFF);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
